// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and helpers for the seven-segment scan driver.
//   - SEG_A..SEG_G       : bit positions of each segment within a 7-bit code
//   - SEG7_GLYPH_AL      : 16-entry active-low hex glyph table (0..9, A, b, C, d, E, F)
//   - seg7_encode()      : nibble -> segment code in the requested polarity
//   - seg7_off()         : all-segments-dark code in the requested polarity
package seg7_pkg;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  // Code order is {a,b,c,d,e,f,g}; a 0 lights the segment.
  localparam logic [6:0] SEG7_GLYPH_AL [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  function automatic logic [6:0] seg7_encode(input logic [3:0] nibble, input logic active_low);
    logic [6:0] glyph;
    glyph = SEG7_GLYPH_AL[nibble];
    return active_low ? glyph : ~glyph;
  endfunction

  function automatic logic [6:0] seg7_off(input logic active_low);
    return active_low ? 7'b1111111 : 7'b0000000;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: valid/ready load channel into the scan driver.
//   load_valid  producer offers a new value
//   load_ready  driver's pending buffer is empty
//   load_value  packed hex nibbles, nibble i -> digit i (digit 0 = least significant)
//   load_dp     decimal-point pattern latched together with load_value
// Modports: master = producer (CPU side), slave = seg7_scan_driver.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      load_valid;
  logic                      load_ready;
  logic [4*NUM_DIGITS-1:0]   load_value;
  logic [NUM_DIGITS-1:0]     load_dp;

  modport master (output load_valid, output load_value, output load_dp, input load_ready);
  modport slave  (input load_valid, input load_value, input load_dp, output load_ready);
endinterface

// File: rtl/seg7_scan_timer.sv
// seg7_scan_timer: slot prescaler and digit index for the multiplexed display.
//   clk, reset   clock and asynchronous active-high reset
//   enable       0 holds prescaler at 0 and index at NUM_DIGITS-1
//   idx_o        digit currently being scanned (counts down, MS digit first)
//   boundary_o   combinational: last cycle of the last slot of a frame
module seg7_scan_timer #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  output logic [IW-1:0] idx_o,
  output logic          boundary_o
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] PRE_TOP = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          slot_wrap_s;

  // Next prescaler/index; disabling parks the scan at the start of a frame.
  always_comb begin
    presc_d     = presc_q;
    idx_d       = idx_q;
    slot_wrap_s = (presc_q == PRE_TOP);
    if (!enable) begin
      presc_d = '0;
      idx_d   = IDX_TOP;
    end else if (slot_wrap_s) begin
      presc_d = '0;
      if (idx_q == '0) begin
        idx_d = IDX_TOP;
      end else begin
        idx_d = idx_q - IW'(1);
      end
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // Scan counter state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      idx_q   <= IDX_TOP;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
    end
  end

  assign idx_o      = idx_q;
  assign boundary_o = enable && slot_wrap_s && (idx_q == '0);

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: double-buffered, time-multiplexed seven-segment controller.
//   clk, reset   clock and asynchronous active-high reset
//   enable       scanning enable (0 = display dark, pending copied straight through)
//   load_if      valid/ready load channel (seg7_scan_driver_if.slave)
//   blank_mask   live per-digit blanking, bit i = 1 keeps digit i dark
//   anode        digit select, one-hot in ACTIVE_LOW polarity
//   seg          segments, seg[6]=a .. seg[0]=g
//   dp           decimal point of the digit being shown
//   frame_done   one-cycle pulse the cycle after each frame boundary
// Optional: define SEG7_LEADING_ZERO_BLANK_EN to darken leading zero digits.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  seg7_scan_driver_if.slave     load_if,
  input  logic [NUM_DIGITS-1:0] blank_mask,
  output logic [NUM_DIGITS-1:0] anode,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_done
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{ACTIVE_LOW}};

  logic [IW-1:0]           idx_s;
  logic                    boundary_s;

  logic                    ready_q, ready_d;
  logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d, disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    frame_done_q, frame_done_d;

  logic [NUM_DIGITS-1:0]   lz_blank_s;
  logic [NUM_DIGITS-1:0]   sel_s;
  logic [3:0]              nib_s;
  logic                    dp_bit_s;
  logic                    hide_s;
  logic                    seen_nz_s;

  seg7_scan_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .idx_o      (idx_s),
    .boundary_o (boundary_s)
  );

  // Pending/display buffers: a load is only promoted at a frame boundary
  // (or any cycle while disabled), so a frame never mixes two values.
  always_comb begin
    ready_d    = ready_q;
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    if (!ready_q && (boundary_s || !enable)) begin
      disp_val_d = pend_val_q;
      disp_dp_d  = pend_dp_q;
      ready_d    = 1'b1;
    end else if (load_if.load_valid && ready_q) begin
      pend_val_d = load_if.load_value;
      pend_dp_d  = load_if.load_dp;
      ready_d    = 1'b0;
    end else begin
      ready_d    = ready_q;
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // Digits above the top nonzero nibble go dark; digit 0 and dp digits stay lit.
  always_comb begin
    lz_blank_s = '0;
    seen_nz_s  = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      seen_nz_s     = seen_nz_s | (disp_val_q[4*i +: 4] != 4'h0);
      lz_blank_s[i] = !seen_nz_s && !disp_dp_q[i];
    end
  end
`else
  // Leading-zero blanking not built: every digit is shown.
  always_comb begin
    lz_blank_s = '0;
    seen_nz_s  = 1'b0;
  end
`endif

  // Select the scanned digit's data and build next-cycle pin values.
  always_comb begin
    sel_s    = '0;
    nib_s    = 4'h0;
    dp_bit_s = 1'b0;
    hide_s   = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_s == IW'(i)) begin
        sel_s[i] = 1'b1;
        nib_s    = disp_val_q[4*i +: 4];
        dp_bit_s = disp_dp_q[i];
        hide_s   = blank_mask[i] | lz_blank_s[i];
      end else begin
        sel_s[i] = 1'b0;
      end
    end
    frame_done_d = boundary_s;
    if (enable && !hide_s) begin
      if (ACTIVE_LOW) begin
        anode_d = ~sel_s;
      end else begin
        anode_d = sel_s;
      end
      seg_d = seg7_encode(nib_s, ACTIVE_LOW);
      dp_d  = dp_bit_s ^ ACTIVE_LOW;
    end else begin
      anode_d = ANODE_OFF;
      seg_d   = seg7_off(ACTIVE_LOW);
      dp_d    = ACTIVE_LOW;
    end
  end

  // Buffer and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q      <= 1'b1;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      anode_q      <= ANODE_OFF;
      seg_q        <= seg7_off(ACTIVE_LOW);
      dp_q         <= ACTIVE_LOW;
      frame_done_q <= 1'b0;
    end else begin
      ready_q      <= ready_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      anode_q      <= anode_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign load_if.load_ready = ready_q;
  assign anode              = anode_q;
  assign seg                = seg_q;
  assign dp                 = dp_q;
  assign frame_done         = frame_done_q;

endmodule
